// File: rtl/calc_pkg.sv
// Shared opcode, error-code and FSM-state definitions for the calc_sequencer slice.
// The optional sticky-error behaviour is selected by CALC_SEQ_STICKY_ERR_EN in calc_sequencer.
package calc_pkg;

    typedef logic [3:0] op_t;
    typedef logic [2:0] err_t;
    typedef logic [1:0] state_t;

    localparam op_t OP_ADD   = 4'd0;
    localparam op_t OP_SUB   = 4'd1;
    localparam op_t OP_MUL   = 4'd2;
    localparam op_t OP_DIV   = 4'd3;
    localparam op_t OP_MOD   = 4'd4;
    localparam op_t OP_LOAD  = 4'd14;
    localparam op_t OP_CLEAR = 4'd15;

    localparam err_t ERR_NONE    = 3'd0;
    localparam err_t ERR_DIV0    = 3'd1;
    localparam err_t ERR_OVF     = 3'd2;
    localparam err_t ERR_ILLEGAL = 3'd3;
    localparam err_t ERR_RANGE   = 3'd4;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // Arithmetic ops occupy the contiguous low codes ADD..MOD.
    function automatic logic op_is_arith(input op_t op);
        return (op <= OP_MOD);
    endfunction

    function automatic logic op_is_legal(input op_t op);
        return op_is_arith(op) || (op == OP_LOAD) || (op == OP_CLEAR);
    endfunction

endpackage

// File: rtl/calc_err_encode.sv
// Combinational error classifier: maps an opcode plus accumulator/ALU status flags
// to a 3-bit error code with priority ILLEGAL > RANGE > DIV0 > OVF.
module calc_err_encode
    import calc_pkg::*;
(
    input  logic [3:0] op,
    input  logic       acc_hi_nonzero,
    input  logic       alu_div0,
    input  logic       alu_ovf,
    output logic [2:0] err
);

    // Priority-ordered classification; DIV0 and OVF only count for the ops that can raise them.
    always_comb begin
        err = ERR_NONE;
        if (!op_is_legal(op)) begin
            err = ERR_ILLEGAL;
        end else if (op_is_arith(op) && acc_hi_nonzero) begin
            err = ERR_RANGE;
        end else if (((op == OP_DIV) || (op == OP_MOD)) && alu_div0) begin
            err = ERR_DIV0;
        end else if (((op == OP_ADD) || (op == OP_SUB)) && alu_ovf) begin
            err = ERR_OVF;
        end else begin
            err = ERR_NONE;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Command sequencer around an external combinational ALU with a RES_W accumulator.
// Optional feature: define CALC_SEQ_STICKY_ERR_EN to latch errors until CLEAR.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RES_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [2:0]        res_err,
    output logic [DATA_W-1:0] alu_p,
    output logic [DATA_W-1:0] alu_q,
    output logic [3:0]        alu_op,
    input  logic [RES_W-1:0]  alu_result,
    input  logic              alu_div0,
    input  logic              alu_ovf
);

    logic [1:0]        state_q,     state_d;
    logic [RES_W-1:0]  acc_q,       acc_d;
    logic [DATA_W-1:0] alu_p_q,     alu_p_d;
    logic [DATA_W-1:0] alu_q_q,     alu_q_d;
    logic [3:0]        alu_op_q,    alu_op_d;
    logic [RES_W-1:0]  res_data_q,  res_data_d;
    logic [2:0]        res_err_q,   res_err_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              res_valid_q, res_valid_d;

    logic              cmd_fire_s;
    logic              acc_hi_nz_s;
    logic [3:0]        enc_op_s;
    logic [2:0]        enc_err_s;
    logic [2:0]        sticky_code_s;
    logic [RES_W-1:0]  load_val_s;

    assign cmd_fire_s  = cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
    assign acc_hi_nz_s = |acc_q[RES_W-1:DATA_W];
    assign load_val_s  = {{(RES_W-DATA_W){1'b0}}, cmd_data};
    // In EXEC classify the issued op; in IDLE the incoming op is only checked for legality.
    assign enc_op_s    = (state_q == ST_EXEC) ? alu_op_q : cmd_op;

    calc_err_encode u_err_encode (
        .op             (enc_op_s),
        .acc_hi_nonzero (acc_hi_nz_s),
        .alu_div0       (alu_div0),
        .alu_ovf        (alu_ovf),
        .err            (enc_err_s)
    );

    // Next-state, accumulator and response computation for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        alu_p_d    = alu_p_q;
        alu_q_d    = alu_q_q;
        alu_op_d   = alu_op_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    if ((sticky_code_s != ERR_NONE) && (cmd_op != OP_CLEAR)) begin
                        res_data_d = acc_q;
                        res_err_d  = sticky_code_s;
                        state_d    = ST_RESP;
                    end else if (op_is_arith(cmd_op)) begin
                        alu_p_d  = acc_q[DATA_W-1:0];
                        alu_q_d  = cmd_data;
                        alu_op_d = cmd_op;
                        state_d  = ST_EXEC;
                    end else if (cmd_op == OP_LOAD) begin
                        acc_d      = load_val_s;
                        res_data_d = load_val_s;
                        res_err_d  = ERR_NONE;
                        state_d    = ST_RESP;
                    end else if (cmd_op == OP_CLEAR) begin
                        acc_d      = {RES_W{1'b0}};
                        res_data_d = {RES_W{1'b0}};
                        res_err_d  = ERR_NONE;
                        state_d    = ST_RESP;
                    end else begin
                        res_data_d = acc_q;
                        res_err_d  = enc_err_s;
                        state_d    = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // Any error discards the ALU result and reports the untouched accumulator.
                if (enc_err_s != ERR_NONE) begin
                    res_data_d = acc_q;
                    res_err_d  = enc_err_s;
                end else begin
                    acc_d      = alu_result;
                    res_data_d = alu_result;
                    res_err_d  = ERR_NONE;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_RESP);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= {RES_W{1'b0}};
            alu_p_q     <= {DATA_W{1'b0}};
            alu_q_q     <= {DATA_W{1'b0}};
            alu_op_q    <= 4'd0;
            res_data_q  <= {RES_W{1'b0}};
            res_err_q   <= ERR_NONE;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            alu_p_q     <= alu_p_d;
            alu_q_q     <= alu_q_d;
            alu_op_q    <= alu_op_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

`ifdef CALC_SEQ_STICKY_ERR_EN
    logic [2:0] sticky_q, sticky_d;
    logic       clear_fire_s;
    logic       resp_enter_s;

    assign clear_fire_s = cmd_fire_s && (cmd_op == OP_CLEAR);
    assign resp_enter_s = (state_q != ST_RESP) && (state_d == ST_RESP);

    // Latch the first reported error code; only CLEAR releases it.
    always_comb begin
        sticky_d = sticky_q;
        if (clear_fire_s) begin
            sticky_d = ERR_NONE;
        end else if (resp_enter_s && (res_err_d != ERR_NONE)) begin
            sticky_d = res_err_d;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= ERR_NONE;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_code_s = sticky_q;
`else
    assign sticky_code_s = ERR_NONE;
`endif

    assign cmd_ready = cmd_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign alu_p     = alu_p_q;
    assign alu_q     = alu_q_q;
    assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: behavioural ALU, high-level accumulator model,
// directed scenarios plus randomized command streams.
module tb_calc_sequencer;

    localparam int DATA_W = 16;
    localparam int RES_W  = 32;

    localparam logic [3:0] T_ADD = 4'd0;
    localparam logic [3:0] T_SUB = 4'd1;
    localparam logic [3:0] T_MUL = 4'd2;
    localparam logic [3:0] T_DIV = 4'd3;
    localparam logic [3:0] T_MOD = 4'd4;
    localparam logic [3:0] T_LD  = 4'd14;
    localparam logic [3:0] T_CLR = 4'd15;

    localparam logic [2:0] E_DIV0  = 3'd1;
    localparam logic [2:0] E_OVF   = 3'd2;
    localparam logic [2:0] E_ILL   = 3'd3;
    localparam logic [2:0] E_RANGE = 3'd4;

`ifdef CALC_SEQ_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  err;
        logic [7:0]  lat;
        logic        rdy;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [3:0]        cmd_op = 4'd0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [RES_W-1:0]  res_data;
    logic [2:0]        res_err;
    logic [DATA_W-1:0] alu_p;
    logic [DATA_W-1:0] alu_q;
    logic [3:0]        alu_op;
    logic [RES_W-1:0]  alu_result;
    logic              alu_div0;
    logic              alu_ovf;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_acc = 32'd0;
    logic [2:0]  m_sticky = 3'd0;
    logic [15:0] m_p = 16'd0;
    logic [15:0] m_q = 16'd0;
    logic [3:0]  m_op = 4'd0;

    calc_sequencer #(.DATA_W(DATA_W), .RES_W(RES_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .alu_p      (alu_p),
        .alu_q      (alu_q),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_div0   (alu_div0),
        .alu_ovf    (alu_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; MUL also raises div0/ovf so that ungated flags are exposed.
    always_comb begin
        logic [31:0] p32;
        logic [31:0] q32;
        p32 = {16'd0, alu_p};
        q32 = {16'd0, alu_q};
        alu_result = 32'd0;
        alu_div0   = 1'b0;
        alu_ovf    = 1'b0;
        case (alu_op)
            T_ADD: begin alu_result = p32 + q32; alu_ovf = (alu_result > 32'd65535); end
            T_SUB: begin alu_result = p32 - q32; alu_ovf = (q32 > p32); end
            T_MUL: begin alu_result = p32 * q32; alu_ovf = (alu_result > 32'd65535); alu_div0 = (q32 == 32'd0); end
            T_DIV: begin alu_div0 = (q32 == 32'd0); alu_result = alu_div0 ? 32'hFFFF_FFFF : p32 / q32; end
            T_MOD: begin alu_div0 = (q32 == 32'd0); alu_result = alu_div0 ? 32'hFFFF_FFFF : p32 % q32; end
            default: alu_result = 32'd0;
        endcase
    end

    function automatic resp_t model_step(input logic [3:0] op, input logic [15:0] d);
        resp_t e;
        longint a;
        longint dl;
        e = '0;
        e.lat = 8'd1;
        a  = longint'(m_acc[15:0]);
        dl = longint'(d);
        if (STICKY && (m_sticky != 3'd0) && (op != T_CLR)) begin
            e.err = m_sticky;
        end else if (op <= T_MOD) begin
            e.lat = 8'd2;
            m_p = m_acc[15:0];
            m_q = d;
            m_op = op;
            if (m_acc > 32'h0000_FFFF) e.err = E_RANGE;
            else if (op == T_ADD) begin
                if (a + dl > 65535) e.err = E_OVF; else m_acc = 32'(a + dl);
            end else if (op == T_SUB) begin
                if (dl > a) e.err = E_OVF; else m_acc = 32'(a - dl);
            end else if (op == T_MUL) m_acc = 32'(a * dl);
            else if (dl == 0) e.err = E_DIV0;
            else if (op == T_DIV) m_acc = 32'(a / dl);
            else m_acc = 32'(a % dl);
        end else if (op == T_LD) begin
            m_acc = {16'd0, d};
        end else if (op == T_CLR) begin
            m_acc = 32'd0;
            m_sticky = 3'd0;
        end else begin
            e.err = E_ILL;
        end
        if (STICKY && (e.err != 3'd0)) m_sticky = e.err;
        e.data = m_acc;
        return e;
    endfunction

    task automatic model_reset();
        m_acc = 32'd0; m_sticky = 3'd0; m_p = 16'd0; m_q = 16'd0; m_op = 4'd0;
    endtask

    // Drives one command, waits (bounded) for the response, holds res_ready low for 'delay' cycles.
    task automatic run_cmd(input logic [3:0] op, input logic [15:0] d, input int delay, output resp_t obs);
        int n;
        obs = '0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n = n + 1; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n = n + 1; end while (!res_valid && n < 20);
        if (res_valid) begin
            obs.lat = 8'(n); obs.data = res_data; obs.err = res_err; obs.rdy = cmd_ready;
        end
        repeat (delay) @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
        checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL reset_res_data got %0h want 0", res_data); end
        checks++; if (res_err !== 3'd0) begin errors++; $display("FAIL reset_res_err got %0d want 0", res_err); end
        checks++; if ({alu_p, alu_q, alu_op} !== 36'd0) begin errors++; $display("FAIL reset_alu got %0h/%0h/%0h want 0", alu_p, alu_q, alu_op); end
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL reset_release got ready=%0b valid=%0b want 1/0", cmd_ready, res_valid); end
    endtask

    task automatic test_directed();
        logic [3:0]  t_op [18] = '{T_CLR, T_LD, T_ADD, T_LD, T_DIV, T_ADD, T_CLR, T_LD, T_MUL, T_ADD,
                                   T_CLR, T_LD, 4'd7, T_ADD, T_CLR, T_ADD, T_SUB, T_MOD};
        logic [15:0] t_d  [18] = '{16'd0, 16'd31, 16'd3, 16'd31, 16'd0, 16'd0, 16'd0, 16'd300, 16'd300, 16'd1,
                                   16'd0, 16'd5, 16'd9, 16'd1, 16'd0, 16'd1, 16'd2, 16'd7};
`ifdef CALC_SEQ_STICKY_ERR_EN
        logic [31:0] x_d  [18] = '{0, 31, 34, 31, 31, 31, 0, 300, 90000, 90000, 0, 5, 5, 5, 0, 1, 1, 1};
        logic [2:0]  x_e  [18] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 4, 0, 0, 3, 3, 0, 0, 2, 2};
        logic [7:0]  x_l  [18] = '{1, 1, 2, 1, 2, 1, 1, 1, 2, 2, 1, 1, 1, 1, 1, 2, 2, 1};
`else
        logic [31:0] x_d  [18] = '{0, 31, 34, 31, 31, 31, 0, 300, 90000, 90000, 0, 5, 5, 6, 0, 1, 1, 1};
        logic [2:0]  x_e  [18] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 4, 0, 0, 3, 0, 0, 0, 2, 0};
        logic [7:0]  x_l  [18] = '{1, 1, 2, 1, 2, 2, 1, 1, 2, 2, 1, 1, 1, 2, 1, 2, 2, 2};
`endif
        resp_t obs;
        resp_t exp;
        for (int i = 0; i < 18; i++) begin
            exp = model_step(t_op[i], t_d[i]);
            run_cmd(t_op[i], t_d[i], 0, obs);
            checks++; if (obs.data !== x_d[i]) begin errors++; $display("FAIL dir%0d_data got %0d want %0d", i, obs.data, x_d[i]); end
            checks++; if (obs.err !== x_e[i]) begin errors++; $display("FAIL dir%0d_err got %0d want %0d", i, obs.err, x_e[i]); end
            checks++; if (obs.lat !== x_l[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, obs.lat, x_l[i]); end
            checks++; if ({alu_p, alu_q, alu_op} !== {m_p, m_q, m_op}) begin errors++;
                $display("FAIL dir%0d_alu got %0h/%0h/%0h want %0h/%0h/%0h", i, alu_p, alu_q, alu_op, m_p, m_q, m_op); end
            checks++; if (exp.data !== x_d[i] || exp.err !== x_e[i]) begin errors++; $display("FAIL dir%0d_model got %0d/%0d want %0d/%0d", i, exp.data, exp.err, x_d[i], x_e[i]); end
        end
    endtask

    task automatic test_hold();
        resp_t obs;
        resp_t exp;
        int n;
        exp = model_step(T_CLR, 16'd0);
        run_cmd(T_CLR, 16'd0, 0, obs);
        exp = model_step(T_LD, 16'd31);
        run_cmd(T_LD, 16'd31, 0, obs);
        exp = model_step(T_ADD, 16'd3);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = T_ADD; cmd_data = 16'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin @(negedge clk); n = n + 1; end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL hold_timeout got valid=%0b want 1", res_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (res_valid !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_handshake got valid=%0b ready=%0b want 1/0", i, res_valid, cmd_ready); end
            checks++; if (res_data !== 32'd34 || res_err !== 3'd0) begin errors++; $display("FAIL hold%0d_data got %0d/%0d want 34/0", i, res_data, res_err); end
        end
        checks++; if (exp.data !== 32'd34) begin errors++; $display("FAIL hold_model got %0d want 34", exp.data); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL hold_release got ready=%0b valid=%0b want 1/0", cmd_ready, res_valid); end
    endtask

    task automatic test_reset_exec();
        resp_t obs;
        resp_t exp;
        exp = model_step(T_CLR, 16'd0);
        run_cmd(T_CLR, 16'd0, 0, obs);
        exp = model_step(T_LD, 16'd31);
        run_cmd(T_LD, 16'd31, 0, obs);
        checks++; if (obs.data !== 32'd31) begin errors++; $display("FAIL rexec_load got %0d want 31", obs.data); end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = T_ADD; cmd_data = 16'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rexec_handshake got valid=%0b ready=%0b want 0/1", res_valid, cmd_ready); end
        checks++; if ({alu_p, alu_q, alu_op} !== 36'd0) begin errors++; $display("FAIL rexec_alu got %0h/%0h/%0h want 0", alu_p, alu_q, alu_op); end
        checks++; if (res_data !== 32'd0 || res_err !== 3'd0) begin errors++; $display("FAIL rexec_res got %0d/%0d want 0/0", res_data, res_err); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rexec_release got valid=%0b ready=%0b want 0/1", res_valid, cmd_ready); end
        exp = model_step(T_ADD, 16'd5);
        run_cmd(T_ADD, 16'd5, 0, obs);
        checks++; if (obs.data !== 32'd5 || obs.err !== 3'd0) begin errors++; $display("FAIL rexec_acc_cleared got %0d/%0d want 5/0", obs.data, obs.err); end
    endtask

    task automatic test_random();
        resp_t obs;
        resp_t exp;
        logic [3:0]  op;
        logic [15:0] d;
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) op = 4'($urandom_range(0, 4));
            case ($urandom_range(0, 3))
                0: d = 16'd0;
                1: d = 16'($urandom_range(0, 20));
                2: d = 16'($urandom_range(0, 65535));
                default: d = 16'($urandom_range(0, 300));
            endcase
            exp = model_step(op, d);
            run_cmd(op, d, int'($urandom_range(0, 3)), obs);
            checks++; if (obs.data !== exp.data) begin errors++; $display("FAIL rnd%0d_data op=%0d d=%0d got %0d want %0d", i, op, d, obs.data, exp.data); end
            checks++; if (obs.err !== exp.err) begin errors++; $display("FAIL rnd%0d_err op=%0d d=%0d got %0d want %0d", i, op, d, obs.err, exp.err); end
            checks++; if (obs.lat !== exp.lat) begin errors++; $display("FAIL rnd%0d_latency op=%0d got %0d want %0d", i, op, obs.lat, exp.lat); end
            checks++; if (obs.rdy !== 1'b0) begin errors++; $display("FAIL rnd%0d_ready_in_resp got %0b want 0", i, obs.rdy); end
            checks++; if ({alu_p, alu_q, alu_op} !== {m_p, m_q, m_op}) begin errors++;
                $display("FAIL rnd%0d_alu got %0h/%0h/%0h want %0h/%0h/%0h", i, alu_p, alu_q, alu_op, m_p, m_q, m_op); end
            checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_return_idle got ready=%0b valid=%0b want 1/0", i, cmd_ready, res_valid); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand width driven to the ALU.
REQ-002 SHALL have parameter RES_W, default 32, ALU result and accumulator width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_op in 4, cmd_data in DATA_W: command channel; transfer on the clk edge where valid and ready are both 1.
REQ-006 SHALL have res_valid out 1, res_ready in 1, res_data out RES_W, res_err out 3: response channel, same transfer rule.
REQ-007 SHALL have alu_p out DATA_W, alu_q out DATA_W, alu_op out 4: registered operands and opcode driven to the ALU.
REQ-008 SHALL have alu_result in RES_W, alu_div0 in 1, alu_ovf in 1: combinational ALU outputs.

Function
REQ-009 Opcodes SHALL be ADD=0, SUB=1, MUL=2, DIV=3, MOD=4, LOAD=14, CLEAR=15; codes 5-13 are illegal.
REQ-010 FSM SHALL have states IDLE, EXEC, RESP; cmd_ready=1 only in IDLE, res_valid=1 only in RESP.
REQ-011 IDLE + command transfer of ADD..MOD SHALL register alu_p=acc[15:0], alu_q=cmd_data, alu_op=cmd_op, and go to EXEC.
REQ-012 EXEC SHALL last exactly one cycle; at its end, the block SHALL sample alu_result/alu_div0/alu_ovf, update acc and res_data/res_err, and go to RESP.
REQ-013 LOAD SHALL set acc={0,cmd_data}; CLEAR SHALL set acc=0 and res_err=0; both skip EXEC (IDLE->RESP) and do not change alu_* outputs.
REQ-014 Illegal opcode SHALL go IDLE->RESP with res_err=ILLEGAL, acc unchanged.
REQ-015 Error codes SHALL be NONE=0, DIV0=1, OVF=2, ILLEGAL=3, RANGE=4; priority ILLEGAL > RANGE > DIV0 > OVF.
REQ-016 RANGE SHALL flag an arithmetic op issued while acc[31:16]!=0; ALU result is discarded.
REQ-017 DIV0 SHALL flag alu_div0 for DIV/MOD only; OVF SHALL flag alu_ovf for ADD/SUB only.
REQ-018 On any error, acc SHALL remain unchanged and res_data SHALL equal the unchanged acc.
REQ-019 On success, acc and res_data SHALL equal alu_result.
REQ-020 Latency SHALL be 2 cycles from command transfer to res_valid for arithmetic ops, and 1 cycle for LOAD/CLEAR/illegal opcodes.
REQ-021 RESP SHALL hold res_valid, res_data and res_err stable until the res_ready transfer, then return to IDLE; cmd_ready SHALL rise on the following cycle (no overlap).

Reset
REQ-022 rst_n=0 at a clock edge SHALL force IDLE from any state, including EXEC and RESP mid-transfer, and discard any pending result.
REQ-023 Reset SHALL clear acc, alu_p, alu_q, alu_op, res_data and res_err to 0, drive res_valid=0, and drive cmd_ready=1 on the first cycle after release.

Configuration
REQ-024 With CALC_SEQ_STICKY_ERR_EN defined, any nonzero error SHALL latch a sticky code.
REQ-025 While the sticky code is set, every command except CLEAR SHALL be accepted and answered with that code, with no ALU issue and no acc change; CLEAR releases the sticky code.
REQ-026 Without CALC_SEQ_STICKY_ERR_EN, errors SHALL apply per response only, and the next command executes normally.

Structure
REQ-027 Shared package calc_pkg SHALL hold the opcode constants, error codes and FSM state encoding.
REQ-028 Sub-module calc_err_encode SHALL be combinational and SHALL map (op, acc_hi_nonzero, alu_div0, alu_ovf) to a 3-bit error code using the REQ-015 priority.

Verification
REQ-029 LOAD 31, then ADD 3 -> res_data=34, res_err=0, res_valid 2 cycles after the ADD transfer.
REQ-030 LOAD 31, then DIV 0 -> res_err=DIV0, res_data=31, acc stays 31.
REQ-031 LOAD 300, MUL 300 (acc=90000), then ADD 1 -> res_err=RANGE, res_data=90000.
REQ-032 cmd_op=7 -> res_err=ILLEGAL one cycle after transfer; with STICKY_ERR_EN, a following ADD 1 returns ILLEGAL, and after CLEAR, ADD 1 returns 1.
REQ-033 Hold res_ready=0 for 5 cycles in RESP -> res_valid, res_data and res_err stay stable and cmd_ready stays 0.
REQ-034 Assert rst_n=0 during EXEC -> next cycle IDLE, res_valid=0, acc=0, cmd_ready=1 after release.
